pal_bus_sequencer: RTL and testbench
====================================

// Module: pal_bus_sequencer
// PURPOSE
// - Upstream stage for the 8-bit tristate output register. Accepts bytes on a
//   valid/ready handshake and sequences them onto that register's val/oe pins.
// - For each byte it runs setup, drive and turnaround phases.
//   - Setup: val is stable one clock edge before the register captures it.
//   - Drive: the bus (oe, active low) is driven for a fixed number of cycles.
//   - Turnaround: the bus is released before the next byte is accepted.
// PARAMETERS
// WIDTH         8   data width; must match the downstream register
// DRIVE_CYCLES  4   cycles oe is held low per byte; must be >= 1
// TURN_CYCLES   1   cycles oe is held high after drive, before next accept; must be >= 1
// PORTS
// clk        input   1      rising-edge clock, shared with the downstream register
// reset      input   1      synchronous, active-high reset
// in_data    input   WIDTH  byte to place on the bus
// in_valid   input   1      in_data is valid
// in_ready   output  1      sequencer can accept; transfer when in_valid && in_ready at a clk edge
// val        output  WIDTH  data to the register's val input
// oe         output  1      active-low bus enable to the register's oe input
// busy       output  1      high from SETUP through the final TURN cycle
// done       output  1      one-cycle pulse in the final TURN cycle
// xfer_count output  16     count of completed bytes; wraps 16'hFFFF -> 0
// BEHAVIOUR
// - Reset
//   - One clock and one synchronous, active-high reset (clk, reset).
//   - All outputs are registered.
//   - While reset is high at an edge: state=IDLE, val=0, oe=1, in_ready=0,
//     busy=0, done=0, xfer_count=0.
//   - On the first edge after reset falls, in_ready becomes 1.
// - States: IDLE -> SETUP -> DRIVE -> TURN -> IDLE
//   - IDLE
//     - in_ready=1, oe=1, busy=0.
//     - val holds its last value.
//     - On in_valid && in_ready at edge E: latch in_data into val, go to SETUP,
//       in_ready=0, busy=1.
//   - SETUP (1 cycle, after E)
//     - val = latched byte, oe=1.
//     - The register captures val at the next edge.
//     - That same edge drives oe to 0 and enters DRIVE.
//   - DRIVE (DRIVE_CYCLES cycles)
//     - oe=0; val is held constant.
//     - A down-counter of width clog2(DRIVE_CYCLES+1) is loaded at SETUP exit.
//     - Leave DRIVE when the counter reaches 1 at an edge.
//   - TURN (TURN_CYCLES cycles)
//     - oe=1; val is held.
//     - done=1 only in the last TURN cycle.
//     - xfer_count increments at the edge that leaves TURN.
//     - That same edge returns to IDLE with in_ready=1.
// - Occupancy
//   - 1 + DRIVE_CYCLES + TURN_CYCLES cycles per byte.
//   - Minimum accept spacing is 2 + DRIVE_CYCLES + TURN_CYCLES edges;
//     there is no back-to-back drive.
// - Handshake
//   - in_valid is ignored outside IDLE; in_data is sampled only at the accept edge.
//   - in_valid may stay high continuously; bytes are then accepted at the
//     minimum spacing.
// - Simultaneous events
//   - reset wins over any accept or state advance at the same edge.
// - Reset mid-operation
//   - Any state returns to IDLE at the reset edge.
//   - oe goes to 1 (bus released) and val goes to 0.
//   - No done pulse; xfer_count is cleared.
//   - The partial byte is lost.
// - Invariant
//   - oe is never 0 in the same cycle val changes.
//   - oe=0 only in DRIVE.
// TESTING
// - Reset: hold reset 3 cycles with in_valid=1
//   -> val=00, oe=1, in_ready=0, xfer_count=0; in_ready=1 one edge after reset falls.
// - Single byte, defaults: accept 8'hA5 at edge E
//   -> SETUP at E..E+1, oe=0 exactly for edges E+2..E+5, oe=1 at E+6;
//      done high for one cycle; in_ready=1 and xfer_count=1 after E+7.
//   - Downstream register out reads A5 during all 4 drive cycles, Z otherwise.
// - Streaming: in_valid held high with bytes 01,02,03
//   -> accepts exactly 7 edges apart; xfer_count=3.
//   - oe high for at least one cycle between bytes.
//   - in_data changes while busy do not alter val.
// - Reset mid-DRIVE: reset asserted on the 2nd DRIVE cycle of byte 3C
//   -> next edge oe=1, val=00, done never pulses, xfer_count=0, in_ready=1 after release.
// - Wrap: force 65536 transfers (or preload through a bench hook)
//   -> xfer_count goes FFFF -> 0000.
// - Parameters DRIVE_CYCLES=1, TURN_CYCLES=3: byte 7E
//   -> oe low exactly 1 cycle; done on the 3rd TURN cycle; accept spacing of 6 edges.

Source files
------------

// File: rtl/pal_bus_sequencer.sv
// Byte sequencer feeding an 8-bit tristate output register: each accepted byte
// runs SETUP (val settles), DRIVE (oe low) and TURN (bus released) phases.
module pal_bus_sequencer #(
  parameter int WIDTH        = 8,
  parameter int DRIVE_CYCLES = 4,
  parameter int TURN_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] val,
  output logic             oe,
  output logic             busy,
  output logic             done,
  output logic [15:0]      xfer_count
);

  localparam int DCW = $clog2(DRIVE_CYCLES + 1);
  localparam int TCW = $clog2(TURN_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [15:0]      xfer_count_q, xfer_count_d;
  logic             ready_q, ready_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    tcnt_d       = tcnt_q;
    val_d        = val_q;
    xfer_count_d = xfer_count_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          val_d   = in_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_DRIVE;
        dcnt_d  = DCW'(DRIVE_CYCLES);
      end
      S_DRIVE: begin
        if (dcnt_q == DCW'(1)) begin
          state_d = S_TURN;
          tcnt_d  = TCW'(TURN_CYCLES);
        end else begin
          dcnt_d = dcnt_q - DCW'(1);
        end
      end
      default: begin
        if (tcnt_q == TCW'(1)) begin
          state_d      = S_IDLE;
          xfer_count_d = xfer_count_q + 16'd1;
        end else begin
          tcnt_d = tcnt_q - TCW'(1);
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    oe_d    = (state_d != S_DRIVE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_TURN) && (tcnt_d == TCW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      val_q        <= '0;
      xfer_count_q <= '0;
      ready_q      <= 1'b0;
      oe_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      tcnt_q       <= tcnt_d;
      val_q        <= val_d;
      xfer_count_q <= xfer_count_d;
      ready_q      <= ready_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = ready_q;
  assign val        = val_q;
  assign oe         = oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_pal_bus_sequencer.sv
// Bench for pal_bus_sequencer: a default instance and a DRIVE=1/TURN=3 instance
// share stimulus; each is tracked by an age-since-accept timeline model.
module tb_pal_bus_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        a_ready, a_oe, a_busy, a_done;
  logic [7:0]  a_val;
  logic [15:0] a_cnt;
  logic        b_ready, b_oe, b_busy, b_done;
  logic [7:0]  b_val;
  logic [15:0] b_cnt;

  int vectors = 0;
  int miscompares = 0;

  pal_bus_sequencer #(.WIDTH(8), .DRIVE_CYCLES(4), .TURN_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .val(a_val), .oe(a_oe), .busy(a_busy),
    .done(a_done), .xfer_count(a_cnt)
  );

  pal_bus_sequencer #(.WIDTH(8), .DRIVE_CYCLES(1), .TURN_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_ready), .val(b_val), .oe(b_oe), .busy(b_busy),
    .done(b_done), .xfer_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = edges since the accept edge (-1 when idle).
  typedef struct {
    int          k;
    logic        rdy;
    logic [7:0]  val;
    logic [15:0] cnt;
  } mdl_t;

  mdl_t ma, mb;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       oe;
    logic       busy;
    logic       done;
    logic [7:0] val;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  function automatic mdl_t mdl_next(input mdl_t s, input int d, input int t,
                                    input logic r, input logic v, input logic [7:0] dat);
    mdl_t n;
    n = s;
    if (r) begin
      n.k = -1; n.rdy = 1'b0; n.val = 8'h00; n.cnt = 16'h0000;
    end else if (s.k >= 0) begin
      n.k = s.k + 1;
      if (n.k == d + t + 1) begin
        n.k = -1; n.cnt = s.cnt + 16'd1; n.rdy = 1'b1;
      end
    end else if (s.rdy && v) begin
      n.k = 0; n.val = dat; n.rdy = 1'b0;
    end else begin
      n.rdy = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag, input mdl_t s, input int d, input int t,
                           input logic rdy, input logic oe, input logic busy, input logic done,
                           input logic [7:0] v, input logic [15:0] cnt);
    chk({tag, ".ready"}, 32'(rdy), 32'(s.rdy));
    chk({tag, ".oe"}, 32'(oe), 32'(!(s.k >= 1 && s.k <= d)));
    chk({tag, ".busy"}, 32'(busy), 32'(s.k >= 0));
    chk({tag, ".done"}, 32'(done), 32'(s.k == d + t));
    chk({tag, ".val"}, 32'(v), 32'(s.val));
    chk({tag, ".cnt"}, 32'(cnt), 32'(s.cnt));
  endtask

  // One clock: inputs applied at the falling edge, outputs checked 1 unit after the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] dat);
    logic [7:0] pa, pb;
    rst = r; in_valid = v; in_data = dat;
    pa = a_val; pb = b_val;
    @(posedge clk);
    ma = mdl_next(ma, 4, 1, r, v, dat);
    mb = mdl_next(mb, 1, 3, r, v, dat);
    #1;
    chk_model("A", ma, 4, 1, a_ready, a_oe, a_busy, a_done, a_val, a_cnt);
    chk_model("B", mb, 1, 3, b_ready, b_oe, b_busy, b_done, b_val, b_cnt);
    if (a_oe == 1'b0) chk("A.val_hold", 32'(a_val), 32'(pa));
    if (b_oe == 1'b0) chk("B.val_hold", 32'(b_val), 32'(pb));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bytes [3];
    int         acc_a[$];
    int         acc_b[$];
    int         ai;
    logic       v;
    logic [7:0] dd;
    logic [5:0] oe_mask, done_mask, rdy_mask;

    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    ma = '{k: -1, rdy: 1'b0, val: 8'h00, cnt: 16'h0000};
    mb = ma;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // Reset with in_valid high, then a single A5 byte on the default instance.
    //            r  v  d      rdy oe busy done val    cnt
    tv.push_back('{1, 1, 8'h5A, 0, 1, 0, 0, 8'h00, 16'd0});
    tv.push_back('{1, 1, 8'h5A, 0, 1, 0, 0, 8'h00, 16'd0});
    tv.push_back('{1, 1, 8'h5A, 0, 1, 0, 0, 8'h00, 16'd0});
    tv.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 16'd0});
    tv.push_back('{0, 1, 8'hA5, 0, 1, 1, 0, 8'hA5, 16'd0});
    tv.push_back('{0, 1, 8'h33, 0, 0, 1, 0, 8'hA5, 16'd0});
    tv.push_back('{0, 0, 8'h33, 0, 0, 1, 0, 8'hA5, 16'd0});
    tv.push_back('{0, 1, 8'h44, 0, 0, 1, 0, 8'hA5, 16'd0});
    tv.push_back('{0, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 16'd0});
    tv.push_back('{0, 1, 8'h55, 0, 1, 1, 1, 8'hA5, 16'd0});
    tv.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 8'hA5, 16'd1});
    tv.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 8'hA5, 16'd1});

    @(negedge clk);
    foreach (tv[i]) begin
      cycle(tv[i].r, tv[i].v, tv[i].d);
      chk($sformatf("vec%0d.ready", i), 32'(a_ready), 32'(tv[i].rdy));
      chk($sformatf("vec%0d.oe", i), 32'(a_oe), 32'(tv[i].oe));
      chk($sformatf("vec%0d.busy", i), 32'(a_busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d.done", i), 32'(a_done), 32'(tv[i].done));
      chk($sformatf("vec%0d.val", i), 32'(a_val), 32'(tv[i].val));
      chk($sformatf("vec%0d.cnt", i), 32'(a_cnt), 32'(tv[i].cnt));
    end

    // Streaming 01,02,03 with in_valid held high; junk data while busy.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    ai = 0;
    for (int n = 0; n < 24; n++) begin
      v  = (ai < 3);
      dd = (a_ready && v) ? bytes[ai] : 8'($urandom);
      if (v && b_ready) acc_b.push_back(n);
      if (v && a_ready) begin
        acc_a.push_back(n);
        ai++;
      end
      cycle(1'b0, v, dd);
    end
    chk("stream.A_accepts", 32'(acc_a.size()), 32'd3);
    chk("stream.B_accepts", 32'(acc_b.size()), 32'd3);
    for (int i = 1; i < acc_a.size(); i++)
      chk($sformatf("stream.A_spacing%0d", i), 32'(acc_a[i] - acc_a[i-1]), 32'd7);
    for (int i = 1; i < acc_b.size(); i++)
      chk($sformatf("stream.B_spacing%0d", i), 32'(acc_b[i] - acc_b[i-1]), 32'd6);
    chk("stream.A_cnt", 32'(a_cnt), 32'd3);
    chk("stream.A_val", 32'(a_val), 32'h03);

    // Reset on the second DRIVE cycle of byte 3C.
    cycle(1'b0, 1'b1, 8'h3C);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    chk("mid.oe_low_before", 32'(a_oe), 32'd0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("mid.oe", 32'(a_oe), 32'd1);
    chk("mid.val", 32'(a_val), 32'h00);
    chk("mid.cnt", 32'(a_cnt), 32'd0);
    chk("mid.ready_in_reset", 32'(a_ready), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    chk("mid.ready_after", 32'(a_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      chk($sformatf("mid.no_done%0d", i), 32'(a_done), 32'd0);
    end

    // Counter wrap: preload near the top, then complete two bytes.
    force dut_a.xfer_count_q = 16'hFFFE;
    #1;
    release dut_a.xfer_count_q;
    ma.cnt = 16'hFFFE;
    cycle(1'b0, 1'b1, 8'h11);
    repeat (7) cycle(1'b0, 1'b0, 8'h00);
    chk("wrap.ffff", 32'(a_cnt), 32'hFFFF);
    cycle(1'b0, 1'b1, 8'h22);
    repeat (7) cycle(1'b0, 1'b0, 8'h00);
    chk("wrap.zero", 32'(a_cnt), 32'h0000);

    // DRIVE=1/TURN=3 instance: single byte 7E, phase positions after the accept edge.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h7E);
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      oe_mask[i-1]   = ~b_oe;
      done_mask[i-1] = b_done;
      rdy_mask[i-1]  = b_ready;
    end
    chk("B7E.oe_low", 32'(oe_mask), 32'b000001);
    chk("B7E.done", 32'(done_mask), 32'b001000);
    chk("B7E.ready", 32'(rdy_mask), 32'b110000);
    chk("B7E.val", 32'(b_val), 32'h7E);
    chk("B7E.cnt", 32'(b_cnt), 32'd1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
